// File: rtl/vfpu_rsp_collector.sv
// Show-ahead response FIFO between the VFPU and the test program, with drop detection.
// Define VFPU_RSP_TIMESTAMP_EN to tag every entry with a 16-bit capture cycle (rsp_ts).
module vfpu_rsp_collector #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int FLAG_W = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   res_vld,
  input  logic [DATA_W-1:0]      res_data,
  input  logic [FLAG_W-1:0]      res_flag,
  output logic                   rsp_vld,
  input  logic                   rsp_rdy,
  output logic [DATA_W-1:0]      rsp_data,
  output logic [FLAG_W-1:0]      rsp_flag,
  output logic [7:0]             rsp_seq,
`ifdef VFPU_RSP_TIMESTAMP_EN
  output logic [15:0]            rsp_ts,
`endif
  output logic [$clog2(DEPTH):0] cnt,
  output logic                   ovf,
  input  logic                   ovf_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [FLAG_W-1:0] flag;
    logic [7:0]        seq;
`ifdef VFPU_RSP_TIMESTAMP_EN
    logic [15:0]       ts;
`endif
  } ent_t;

  ent_t          mem [DEPTH];
  ent_t          wr_ent;
  ent_t          head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [7:0]    seq_cnt;
  logic          full;
  logic          push;
  logic          pop;
  logic          drop;
`ifdef VFPU_RSP_TIMESTAMP_EN
  logic [15:0]   ts_cnt;
`endif

  assign full = (cnt == FULL);
  assign rsp_vld = rst_n && (cnt != '0);
  assign pop  = rsp_vld && rsp_rdy;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push = rst_n && res_vld && (!full || pop);
  assign drop = rst_n && res_vld && full && !pop;

  always_comb begin
    wr_ent      = '0;
    wr_ent.data = res_data;
    wr_ent.flag = res_flag;
    wr_ent.seq  = seq_cnt;
`ifdef VFPU_RSP_TIMESTAMP_EN
    wr_ent.ts   = ts_cnt;
`endif
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_ent;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
      seq_cnt <= '0;
      ovf     <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      cnt <= cnt + CW'(1);
      else if (pop && !push) cnt <= cnt - CW'(1);
      if (res_vld) seq_cnt <= seq_cnt + 8'd1;
      if (drop)         ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

`ifdef VFPU_RSP_TIMESTAMP_EN
  always_ff @(posedge clk) begin
    if (!rst_n) ts_cnt <= '0;
    else        ts_cnt <= ts_cnt + 16'd1;
  end
`endif

  // Empty or in reset the head fields read zero rather than stale storage.
  assign head     = rsp_vld ? mem[rd_ptr] : '0;
  assign rsp_data = head.data;
  assign rsp_flag = head.flag;
  assign rsp_seq  = head.seq;
`ifdef VFPU_RSP_TIMESTAMP_EN
  assign rsp_ts   = head.ts;
`endif

endmodule

// File: doc/vfpu_rsp_collector.md
VFPU_RSP_COLLECTOR -- requirements
Module: vfpu_rsp_collector

Interface
REQ-001 SHALL have parameter DATA_W, default 32, result data width.
REQ-002 SHALL have parameter DEPTH, default 8, FIFO entries; power of 2, at least 2.
REQ-003 SHALL have parameter FLAG_W, default 5, IEEE exception flags (NV, DZ, OF, UF, NX).
REQ-004 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  single clock; all logic on posedge.
- rst_n  in  1  reset; synchronous, active-low.
- res_vld  in  1  DUT result strobe; no backpressure to the DUT.
- res_data  in  DATA_W  DUT result.
- res_flag  in  FLAG_W  DUT exception flags.
- rsp_vld  out  1  response available to the test program.
- rsp_rdy  in  1  test program accepts the response.
- rsp_data  out  DATA_W  head-entry data.
- rsp_flag  out  FLAG_W  head-entry flags.
- rsp_seq  out  8  head-entry sequence number.
- rsp_ts  out  16  head-entry capture cycle; present only with VFPU_RSP_TIMESTAMP_EN.
- cnt  out  log2(DEPTH)+1  occupancy.
- ovf  out  1  sticky overflow.
- ovf_clr  in  1  clears ovf.

Function
REQ-005 SHALL buffer DUT results in a show-ahead FIFO and return them to the test program over a valid/ready handshake.
REQ-006 Push SHALL occur when res_vld=1 and a slot is free; the entry holds {res_data, res_flag, seq_cnt}.
REQ-007 Pop SHALL occur when rsp_vld=1 and rsp_rdy=1.
REQ-008 rsp_vld SHALL equal (cnt != 0); rsp_data, rsp_flag, rsp_seq and rsp_ts SHALL reflect the head entry combinationally.
REQ-009 Latency SHALL be exactly 1: a push at edge N gives rsp_vld=1 after edge N, with no bypass.
REQ-010 Push into an empty FIFO while rsp_rdy=1 SHALL NOT pop in that same cycle.
REQ-011 rsp_vld SHALL remain asserted and the head fields stable until the pop.
REQ-012 seq_cnt (8 bit) SHALL increment on every res_vld=1 cycle, whether or not the result is stored, and SHALL wrap 255->0, so the test program detects drops as sequence gaps.
REQ-013 Push with pop in the same cycle SHALL leave cnt unchanged, including when the FIFO is full: the pop frees the slot and the push is accepted.
REQ-014 res_vld=1 while cnt=DEPTH and no pop SHALL drop the result and set ovf=1; FIFO contents SHALL stay unchanged.
REQ-015 ovf SHALL clear on ovf_clr=1; if a drop occurs in the same cycle, set SHALL win.
REQ-016 Read and write pointers SHALL wrap modulo DEPTH.
REQ-017 cnt SHALL never exceed DEPTH.
REQ-018 rsp_rdy=1 while the FIFO is empty SHALL have no effect.

Reset
REQ-019 rst_n=0 sampled at a posedge SHALL clear pointers, cnt, seq_cnt, ovf and the timestamp counter.
REQ-020 Under reset, rsp_vld SHALL be 0 and rsp_data, rsp_flag, rsp_seq and rsp_ts SHALL read 0.
REQ-021 Reset mid-operation SHALL discard all buffered entries.
REQ-022 res_vld SHALL be ignored while rst_n=0.
REQ-023 The first res_vld after reset release SHALL carry seq 0.

Configuration
REQ-024 With VFPU_RSP_TIMESTAMP_EN defined:
- a free-running 16-bit cycle counter, cleared by reset and wrapping 65535->0, SHALL be captured into each pushed entry;
- rsp_ts SHALL present the head entry's capture value.
REQ-025 Without VFPU_RSP_TIMESTAMP_EN, the rsp_ts port, the counter and the storage SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-026 Reset release; res_vld=1 for one cycle, data 0x3F800000, flags 5'b00001 -> rsp_vld=1 one cycle later with rsp_data=0x3F800000, rsp_flag=1, rsp_seq=0; with macro, rsp_ts = push cycle count.
REQ-027 rsp_rdy=0; push 10 results with DEPTH=8 -> cnt=8, ovf=1; draining gives seq 0..7; next accepted push gets seq 10.
REQ-028 FIFO full, res_vld=1 and rsp_rdy=1 in the same cycle -> cnt stays 8, ovf stays 0, new entry at the tail.
REQ-029 Drive 300 results with rsp_rdy=1 -> rsp_seq wraps 255->0; no loss; cnt<=1.
REQ-030 Four entries buffered, rst_n=0 for one cycle -> cnt=0, rsp_vld=0, ovf=0; next push has seq 0.
REQ-031 ovf=1, ovf_clr=1 coincident with an overflow drop -> ovf stays 1; next cycle ovf_clr=1 with no drop -> ovf=0.
